// File: rtl/fetch_predpc.sv
// Fetch-stage PC predictor and F pipeline register for the Y86 pipeline.
// Calls/jumps predict taken (valC); rets predict from a speculative RAS repaired from a committed copy.
module fetch_predpc #(
  parameter int                ADDR_W    = 64,
  parameter int                RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              F_stall_i,
  input  logic              W_stall_i,
  input  logic [3:0]        f_icode_i,
  input  logic [ADDR_W-1:0] f_valC_i,
  input  logic [ADDR_W-1:0] f_valP_i,
  input  logic [3:0]        M_icode_i,
  input  logic              M_Cnd_i,
  input  logic [3:0]        W_icode_i,
  input  logic [ADDR_W-1:0] W_valM_i,
  output logic [ADDR_W-1:0] F_predPC_o,
  output logic              ras_empty_o,
  output logic              ret_mispred_o,
  output logic [31:0]       ret_ok_cnt_o
);

  localparam int SP_W  = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [3:0]       IJXX    = 4'h7;
  localparam logic [3:0]       ICALL   = 4'h8;
  localparam logic [3:0]       IRET    = 4'h9;
  localparam logic [SP_W-1:0]  SP_ONE  = SP_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [RAS_DEPTH-1:0][ADDR_W-1:0] ras;
  logic [SP_W-1:0]  spec_sp,  spec_sp_nxt,  commit_sp,  commit_sp_nxt;
  logic [CNT_W-1:0] spec_cnt, spec_cnt_nxt, commit_cnt, commit_cnt_nxt;

  logic              fire, f_call, f_ret, w_ret, ret_bad, recover;
  logic [ADDR_W-1:0] spec_top, commit_top, next_pred;

  always_comb begin
    fire       = !F_stall_i;
    f_call     = fire && (f_icode_i == ICALL);
    f_ret      = fire && (f_icode_i == IRET);
    spec_top   = ras[spec_sp - SP_ONE];
    commit_top = ras[commit_sp - SP_ONE];

    next_pred = f_valP_i;
    if (f_icode_i == IJXX || f_icode_i == ICALL)
      next_pred = f_valC_i;
    else if (f_icode_i == IRET && spec_cnt != '0)
      next_pred = spec_top;

    // Ret target check uses the committed stack as it stood before this cycle's retire.
    w_ret   = !W_stall_i && (W_icode_i == IRET);
    ret_bad = w_ret && ((commit_cnt == '0) || (commit_top != W_valM_i));
    recover = ((M_icode_i == IJXX) && !M_Cnd_i) || ret_bad;

    commit_sp_nxt  = commit_sp;
    commit_cnt_nxt = commit_cnt;
    if (!W_stall_i && W_icode_i == ICALL) begin
      commit_sp_nxt  = commit_sp + SP_ONE;
      commit_cnt_nxt = (commit_cnt == CNT_MAX) ? commit_cnt : commit_cnt + CNT_ONE;
    end else if (w_ret && commit_cnt != '0) begin
      commit_sp_nxt  = commit_sp - SP_ONE;
      commit_cnt_nxt = commit_cnt - CNT_ONE;
    end

    spec_sp_nxt  = spec_sp;
    spec_cnt_nxt = spec_cnt;
    if (recover) begin
      spec_sp_nxt  = commit_sp_nxt;
      spec_cnt_nxt = commit_cnt_nxt;
    end else if (f_call) begin
      spec_sp_nxt  = spec_sp + SP_ONE;
      spec_cnt_nxt = (spec_cnt == CNT_MAX) ? spec_cnt : spec_cnt + CNT_ONE;
    end else if (f_ret && spec_cnt != '0) begin
      spec_sp_nxt  = spec_sp - SP_ONE;
      spec_cnt_nxt = spec_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ras           <= '0;
      spec_sp       <= '0;
      spec_cnt      <= '0;
      commit_sp     <= '0;
      commit_cnt    <= '0;
      F_predPC_o    <= RESET_PC;
      ret_mispred_o <= 1'b0;
      ret_ok_cnt_o  <= '0;
    end else begin
      // Wrong-path calls still write data; only the pointers are repaired.
      if (f_call)
        ras[spec_sp] <= f_valP_i;
      if (fire)
        F_predPC_o <= next_pred;
      spec_sp       <= spec_sp_nxt;
      spec_cnt      <= spec_cnt_nxt;
      commit_sp     <= commit_sp_nxt;
      commit_cnt    <= commit_cnt_nxt;
      ret_mispred_o <= ret_bad;
      if (w_ret && !ret_bad)
        ret_ok_cnt_o <= ret_ok_cnt_o + 32'd1;
    end
  end

  assign ras_empty_o = (spec_cnt == '0);

endmodule

// File: tb/tb_fetch_predpc.sv
// Directed table, overflow/reset sequences and a randomized run against an arithmetic RAS model.
module tb_fetch_predpc;

  localparam int D = 8;
  localparam logic [3:0] INOP = 4'h1, IJXX = 4'h7, ICALL = 4'h8, IRET = 4'h9;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        fstall, wstall, mcnd;
  logic [3:0]  ficode, micode, wicode;
  logic [63:0] valc, valp, wvalm;
  logic [63:0] pred;
  logic        empty, mis;
  logic [31:0] okcnt;

  int n_vec = 0, n_bad = 0;

  fetch_predpc dut (
    .clk_i(clk), .rst_n_i(rst_n), .F_stall_i(fstall), .W_stall_i(wstall),
    .f_icode_i(ficode), .f_valC_i(valc), .f_valP_i(valp),
    .M_icode_i(micode), .M_Cnd_i(mcnd), .W_icode_i(wicode), .W_valM_i(wvalm),
    .F_predPC_o(pred), .ras_empty_o(empty), .ret_mispred_o(mis), .ret_ok_cnt_o(okcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic fs, ws; logic [3:0] fi; logic [63:0] vc, vp;
    logic [3:0] mi; logic mc; logic [3:0] wi; logic [63:0] wv;
    logic [63:0] e_pred; logic e_empty, e_mis; logic [31:0] e_ok;
  } vec_t;

  vec_t tbl[16];

  // Reference: unbounded integer pointers, storage slot = pointer mod depth.
  logic [63:0] m_mem[D];
  int          m_ssp, m_scnt, m_csp, m_ccnt;
  logic [63:0] m_pred;
  logic        m_mis;
  logic [31:0] m_ok;

  function automatic vec_t mk(input logic fs, ws, input logic [3:0] fi, input logic [63:0] vc, vp,
                              input logic [3:0] mi, input logic mc, input logic [3:0] wi,
                              input logic [63:0] wv, ep, input logic ee, em, input logic [31:0] eo);
    vec_t v;
    v.fs = fs; v.ws = ws; v.fi = fi; v.vc = vc; v.vp = vp; v.mi = mi; v.mc = mc;
    v.wi = wi; v.wv = wv; v.e_pred = ep; v.e_empty = ee; v.e_mis = em; v.e_ok = eo;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    m_ssp = 0; m_scnt = 0; m_csp = 0; m_ccnt = 0;
    m_pred = '0; m_mis = 1'b0; m_ok = '0;
  endtask

  task automatic model_clock();
    logic [63:0] np;
    logic bad;
    int ncsp, nccnt;
    np = valp;
    if (ficode == IJXX || ficode == ICALL) np = valc;
    else if (ficode == IRET && m_scnt > 0) np = m_mem[(m_ssp - 1) % D];
    bad = !wstall && wicode == IRET && (m_ccnt == 0 || m_mem[(m_csp - 1) % D] != wvalm);
    ncsp = m_csp; nccnt = m_ccnt;
    if (!wstall && wicode == ICALL) begin
      ncsp++; nccnt = (nccnt < D) ? nccnt + 1 : D;
    end else if (!wstall && wicode == IRET && nccnt > 0) begin
      ncsp--; nccnt--;
    end
    if (!fstall && ficode == ICALL) m_mem[m_ssp % D] = valp;
    if (bad || (micode == IJXX && !mcnd)) begin
      m_ssp = ncsp; m_scnt = nccnt;
    end else if (!fstall && ficode == ICALL) begin
      m_ssp++; m_scnt = (m_scnt < D) ? m_scnt + 1 : D;
    end else if (!fstall && ficode == IRET && m_scnt > 0) begin
      m_ssp--; m_scnt--;
    end
    m_csp = ncsp; m_ccnt = nccnt;
    if (!fstall) m_pred = np;
    if (!wstall && wicode == IRET && !bad) m_ok++;
    m_mis = bad;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    fstall = v.fs; wstall = v.ws; ficode = v.fi; valc = v.vc; valp = v.vp;
    micode = v.mi; mcnd = v.mc; wicode = v.wi; wvalm = v.wv;
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic fetch(input logic [3:0] fi, input logic [63:0] vc, vp);
    drive(mk(0, 0, fi, vc, vp, INOP, 1, INOP, 0, 0, 0, 0, 0));
    step();
  endtask

  initial begin
    tbl[0]  = mk(0,0,ICALL,64'h100,64'h20, INOP,1,INOP,0,      64'h100,0,0,0);
    tbl[1]  = mk(0,0,IRET, 64'h0,  64'h101,INOP,1,INOP,0,      64'h20, 1,0,0);
    tbl[2]  = mk(0,0,INOP, 64'h0,  64'h22, INOP,1,ICALL,0,     64'h22, 1,0,0);
    tbl[3]  = mk(0,0,INOP, 64'h0,  64'h23, INOP,1,IRET,64'h20, 64'h23, 1,0,1);
    tbl[4]  = mk(1,0,ICALL,64'h500,64'h600,INOP,1,INOP,0,      64'h23, 1,0,1);
    tbl[5]  = mk(1,0,ICALL,64'h500,64'h600,INOP,1,INOP,0,      64'h23, 1,0,1);
    tbl[6]  = mk(1,0,ICALL,64'h500,64'h600,INOP,1,INOP,0,      64'h23, 1,0,1);
    tbl[7]  = mk(0,0,IRET, 64'h0,  64'h30, INOP,1,INOP,0,      64'h30, 1,0,1);
    tbl[8]  = mk(0,0,ICALL,64'h200,64'h40, INOP,1,INOP,0,      64'h200,0,0,1);
    tbl[9]  = mk(0,0,INOP, 64'h0,  64'h41, INOP,1,ICALL,0,     64'h41, 0,0,1);
    tbl[10] = mk(0,0,ICALL,64'h300,64'h50, INOP,1,INOP,0,      64'h300,0,0,1);
    tbl[11] = mk(0,0,ICALL,64'h310,64'h60, INOP,1,INOP,0,      64'h310,0,0,1);
    tbl[12] = mk(0,0,INOP, 64'h0,  64'h70, IJXX,0,INOP,0,      64'h70, 0,0,1);
    tbl[13] = mk(0,0,IRET, 64'h0,  64'h71, INOP,1,INOP,0,      64'h40, 1,0,1);
    tbl[14] = mk(0,0,ICALL,64'h400,64'h80, INOP,1,IRET,64'h200,64'h400,1,1,1);
    tbl[15] = mk(0,0,INOP, 64'h0,  64'h81, INOP,1,INOP,0,      64'h81, 1,0,1);

    drive(mk(0, 0, INOP, 0, 0, INOP, 1, INOP, 0, 0, 0, 0, 0));
    model_reset();
    #3;
    chk("reset_pred", pred, 64'h0);
    chk("reset_empty", {63'h0, empty}, 64'h1);
    chk("reset_mis", {63'h0, mis}, 64'h0);
    chk("reset_ok", {32'h0, okcnt}, 64'h0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i]);
      step();
      chk($sformatf("tbl%0d_pred", i), pred, tbl[i].e_pred);
      chk($sformatf("tbl%0d_empty", i), {63'h0, empty}, {63'h0, tbl[i].e_empty});
      chk($sformatf("tbl%0d_mis", i), {63'h0, mis}, {63'h0, tbl[i].e_mis});
      chk($sformatf("tbl%0d_ok", i), {32'h0, okcnt}, {32'h0, tbl[i].e_ok});
    end

    // Mid-run asynchronous reset with nonzero state.
    fetch(ICALL, 64'h777, 64'h88);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_pred", pred, 64'h0);
    chk("midrst_empty", {63'h0, empty}, 64'h1);
    chk("midrst_mis", {63'h0, mis}, 64'h0);
    chk("midrst_ok", {32'h0, okcnt}, 64'h0);
    @(negedge clk) rst_n = 1'b1;

    // Overflow: nine calls into an eight-deep stack, then nine rets.
    for (int k = 1; k <= 9; k++) begin
      fetch(ICALL, 64'h1000 + 64'(k), 64'(16 * k));
      chk($sformatf("ovf_call%0d", k), pred, 64'h1000 + 64'(k));
    end
    for (int i = 1; i <= 9; i++) begin
      fetch(IRET, 64'h0, 64'h900 + 64'(i));
      chk($sformatf("ovf_ret%0d", i), pred, (i <= 8) ? 64'(16 * (10 - i)) : 64'h909);
      chk($sformatf("ovf_empty%0d", i), {63'h0, empty}, {63'h0, (i >= 8)});
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      logic [3:0] fi_tab[6];
      logic [3:0] wi_tab[4];
      fi_tab = '{ICALL, ICALL, IRET, IRET, IJXX, INOP};
      wi_tab = '{ICALL, IRET, IRET, INOP};
      fstall = ($urandom_range(0, 4) == 0);
      wstall = ($urandom_range(0, 4) == 0);
      ficode = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : fi_tab[$urandom_range(0, 5)];
      valc   = {32'h0, $urandom};
      valp   = {32'h0, $urandom};
      micode = ($urandom_range(0, 7) == 0) ? IJXX : INOP;
      mcnd   = 1'($urandom_range(0, 1));
      wicode = wi_tab[$urandom_range(0, 3)];
      wvalm  = (m_ccnt > 0 && $urandom_range(0, 3) != 0) ? m_mem[(m_csp - 1) % D] : {32'h0, $urandom};
      step();
      chk("rnd_pred", pred, m_pred);
      chk("rnd_empty", {63'h0, empty}, {63'h0, (m_scnt == 0)});
      chk("rnd_mis", {63'h0, mis}, {63'h0, m_mis});
      chk("rnd_ok", {32'h0, okcnt}, {32'h0, m_ok});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
